// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target: pin synchronizers, one-byte tx holding buffer, rx byte output.
// Frames are MSB first; the holding buffer feeds tx_shift at frame start and after every 8th sclk rise.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       underrun
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  state_e                 state_q, state_d;
  logic [7:0]             tx_buf_q, tx_buf_d;
  logic                   buf_full_q, buf_full_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   reload_q, reload_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;
  logic [1:0]             gap_q, gap_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, load;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign miso     = (state_q == SHIFT) & tx_shift_q[7];
  assign miso_oe  = (state_q == SHIFT);
  assign tx_ready = ~buf_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    buf_full_d = buf_full_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    reload_d   = reload_q;
    rx_valid_d = 1'b0;
    overrun_d  = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;
    // gap_q counts cycles since the last rx_valid, saturating at 3
    gap_d      = (gap_q == 2'd3) ? gap_q : gap_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          reload_d   = 1'b0;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_d    = IDLE;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          reload_d   = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            reload_d = 1'b1;
            if (gap_q != 2'd3) begin
              overrun_d = 1'b1;
            end else begin
              rx_data_d  = {rx_shift_q[6:0], mosi_s};
              rx_valid_d = 1'b1;
              gap_d      = 2'd0;
            end
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            load     = 1'b1;
            reload_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load before accepting a new byte so a same-cycle handshake lands in the emptied buffer
    if (load) begin
      if (buf_full_q) begin
        tx_shift_d = tx_buf_q;
      end else begin
        tx_shift_d = 8'h00;
        underrun_d = 1'b1;
      end
      buf_full_d = 1'b0;
    end
    if (tx_valid && tx_ready) begin
      tx_buf_d   = tx_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      tx_buf_q    <= 8'h00;
      buf_full_q  <= 1'b0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      bit_cnt_q   <= 3'd0;
      reload_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      gap_q       <= 2'd3;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      tx_buf_q    <= tx_buf_d;
      buf_full_q  <= buf_full_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      reload_q    <= reload_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target with a byte-level controller model.
module tb_spi_target;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi, tx_valid;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, overrun, underrun;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_target #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .overrun(overrun), .underrun(underrun)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         under_cnt = 0;
  int         over_cnt = 0;
  int         exp_under = 0;
  logic       rxv_prev = 1'b0;
  logic [7:0] rx_got[$];
  logic [7:0] mosi_bytes[$];
  logic [7:0] miso_got[$];
  logic [7:0] miso_exp[$];
  logic [7:0] feed_q[$];
  logic [7:0] mdl_buf = 8'h00;
  bit         mdl_full = 1'b0;
  bit         oe_ok;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rx_valid) begin
        n_checks++;
        if (rxv_prev) begin
          n_fail++;
          $display("FAIL rx_valid_width: high for more than one cycle, required one");
        end
        rx_got.push_back(rx_data);
      end
      if (underrun) under_cnt++;
      if (overrun) over_cnt++;
    end
    rxv_prev = rx_valid;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 400) begin
      cycles(1);
      n++;
    end
    if (!tx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_tx_timeout: tx_ready=0 after %0d cycles, required 1", n);
    end else begin
      tx_data  = b;
      tx_valid = 1'b1;
      cycles(1);
      tx_valid = 1'b0;
      mdl_buf  = b;
      mdl_full = 1'b1;
    end
  endtask

  task automatic feed(input int delay);
    cycles(delay);
    while (feed_q.size() > 0) push_tx(feed_q.pop_front());
  endtask

  // Controller side of one frame; the expected miso byte is whatever the one-deep buffer model holds at each byte start
  task automatic run_frame(input int nbits, input int ph);
    logic [7:0] got, cur;
    miso_got.delete();
    miso_exp.delete();
    oe_ok = 1'b1;
    got   = 8'h00;
    cs_n  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 0) begin
        miso_exp.push_back(mdl_full ? mdl_buf : 8'h00);
        if (!mdl_full) exp_under++;
        mdl_full = 1'b0;
      end
      cur  = mosi_bytes[i / 8];
      mosi = cur[7 - i % 8];
      cycles(ph);
      got = {got[6:0], miso};
      if (!miso_oe) oe_ok = 1'b0;
      if (i % 8 == 7) miso_got.push_back(got);
      sclk = 1'b1;
      cycles(ph);
      sclk = 1'b0;
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    cycles(3 * ph + 4);
  endtask

  task automatic test_reset();
    rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    cycles(3);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", miso); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_checks++; if ({rx_valid, overrun, underrun} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {rx_valid, overrun, underrun}); end
    rst = 1'b1;
    cycles(4);
  endtask

  task automatic test_basic();
    int u0;
    u0 = under_cnt;
    push_tx(8'hA5);
    mosi_bytes = '{8'h3C};
    rx_got.delete();
    run_frame(8, 6);
    n_checks++; if (miso_got.size() != 1 || miso_got[0] !== 8'hA5) begin n_fail++; $display("FAIL basic_miso: got %h want a5", miso_got.size() ? miso_got[0] : 8'h00); end
    n_checks++; if (rx_got.size() != 1) begin n_fail++; $display("FAIL basic_rx_count: got %0d want 1", rx_got.size()); end
    else begin n_checks++; if (rx_got[0] !== 8'h3C) begin n_fail++; $display("FAIL basic_rx_data: got %h want 3c", rx_got[0]); end end
    n_checks++; if (under_cnt != u0) begin n_fail++; $display("FAIL basic_underrun: got %0d pulses want 0", under_cnt - u0); end
    n_checks++; if (!oe_ok) begin n_fail++; $display("FAIL basic_oe_in_frame: got 0 want 1"); end
    n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL basic_oe_after: got %b want 0", miso_oe); end
  endtask

  task automatic test_burst(input int ph, input string tag, input int rnd);
    int u0, e0;
    logic [7:0] t0;
    u0 = under_cnt; e0 = exp_under;
    if (rnd != 0) begin
      t0 = 8'($urandom);
      mosi_bytes = '{8'($urandom), 8'($urandom), 8'($urandom)};
      feed_q = '{8'($urandom), 8'($urandom)};
    end else begin
      t0 = 8'h01;
      mosi_bytes = '{8'hF0, 8'h0F, 8'hFF};
      feed_q = '{8'h02, 8'h03};
    end
    push_tx(t0);
    rx_got.delete();
    fork
      run_frame(24, ph);
      feed(ph + 4);
    join
    n_checks++; if (rx_got.size() != 3) begin n_fail++; $display("FAIL %s_rx_count: got %0d want 3", tag, rx_got.size()); end
    for (int k = 0; k < 3 && k < rx_got.size(); k++) begin
      n_checks++; if (rx_got[k] !== mosi_bytes[k]) begin n_fail++; $display("FAIL %s_rx_data[%0d]: got %h want %h", tag, k, rx_got[k], mosi_bytes[k]); end
    end
    for (int k = 0; k < 3 && k < miso_got.size(); k++) begin
      n_checks++; if (miso_got[k] !== miso_exp[k]) begin n_fail++; $display("FAIL %s_miso[%0d]: got %h want %h", tag, k, miso_got[k], miso_exp[k]); end
    end
    if (rnd == 0) begin
      n_checks++; if (miso_got.size() != 3 || miso_got[2] !== 8'h03) begin n_fail++; $display("FAIL %s_miso_last: got %h want 03", tag, miso_got.size() == 3 ? miso_got[2] : 8'h00); end
    end
    n_checks++; if (under_cnt - u0 != exp_under - e0) begin n_fail++; $display("FAIL %s_underrun: got %0d want %0d", tag, under_cnt - u0, exp_under - e0); end
  endtask

  task automatic test_underrun();
    int u0;
    u0 = under_cnt;
    mosi_bytes = '{8'($urandom)};
    rx_got.delete();
    run_frame(8, 5);
    n_checks++; if (under_cnt - u0 != 1) begin n_fail++; $display("FAIL underrun_pulses: got %0d want 1", under_cnt - u0); end
    n_checks++; if (miso_got.size() != 1 || miso_got[0] !== 8'h00) begin n_fail++; $display("FAIL underrun_miso: got %h want 00", miso_got.size() ? miso_got[0] : 8'hFF); end
    n_checks++; if (rx_got.size() != 1 || rx_got[0] !== mosi_bytes[0]) begin n_fail++; $display("FAIL underrun_rx: got %0d bytes want 1 of %h", rx_got.size(), mosi_bytes[0]); end
  endtask

  task automatic test_idle_sclk();
    int u0;
    u0 = under_cnt;
    rx_got.delete();
    mosi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sclk = 1'b1; cycles(5);
      sclk = 1'b0; cycles(5);
    end
    mosi = 1'b0;
    cycles(6);
    n_checks++; if (rx_got.size() != 0) begin n_fail++; $display("FAIL idle_sclk_rx: got %0d bytes want 0", rx_got.size()); end
    n_checks++; if (miso_oe !== 1'b0 || under_cnt != u0) begin n_fail++; $display("FAIL idle_sclk_state: oe %b underruns %0d want 0 0", miso_oe, under_cnt - u0); end
  endtask

  task automatic test_abort();
    logic [7:0] x, y;
    x = 8'($urandom); y = 8'($urandom);
    push_tx(x);
    feed_q = '{y};
    mosi_bytes = '{8'($urandom)};
    rx_got.delete();
    fork
      run_frame(5, 6);
      feed(10);
    join
    n_checks++; if (rx_got.size() != 0) begin n_fail++; $display("FAIL abort_rx: got %0d bytes want 0", rx_got.size()); end
    n_checks++; if (miso_oe !== 1'b0 || !oe_ok) begin n_fail++; $display("FAIL abort_oe: after %b in_frame %b want 0 1", miso_oe, oe_ok); end
    mosi_bytes = '{8'h81};
    run_frame(8, 6);
    n_checks++; if (rx_got.size() != 1 || rx_got[0] !== 8'h81) begin n_fail++; $display("FAIL abort_next_rx: got %0d bytes first %h want 81", rx_got.size(), rx_got.size() ? rx_got[0] : 8'h00); end
    n_checks++; if (miso_got.size() != 1 || miso_got[0] !== y || miso_exp[0] !== y) begin n_fail++; $display("FAIL abort_kept_buffer: got %h want %h", miso_got.size() ? miso_got[0] : 8'h00, y); end
  endtask

  task automatic test_reset_mid();
    int u0, e0;
    push_tx(8'($urandom));
    cs_n = 1'b0;
    mdl_full = 1'b0;
    cycles(6);
    push_tx(8'($urandom));
    for (int i = 0; i < 3; i++) begin
      mosi = i[0];
      cycles(5); sclk = 1'b1;
      cycles(5); sclk = 1'b0;
    end
    cycles(2);
    rst = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cycles(2);
    n_checks++; if (miso !== 1'b0 || miso_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_pins: miso %b oe %b want 0 0", miso, miso_oe); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_ready); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    n_checks++; if ({rx_valid, overrun, underrun} !== 3'b000) begin n_fail++; $display("FAIL rstmid_pulses: got %b want 000", {rx_valid, overrun, underrun}); end
    rst = 1'b1;
    mdl_full = 1'b0;
    cycles(4);
    u0 = under_cnt; e0 = exp_under;
    push_tx(8'($urandom));
    mosi_bytes = '{8'($urandom)};
    rx_got.delete();
    run_frame(8, 6);
    n_checks++; if (rx_got.size() != 1 || rx_got[0] !== mosi_bytes[0]) begin n_fail++; $display("FAIL rstmid_next_rx: got %0d bytes want 1 of %h", rx_got.size(), mosi_bytes[0]); end
    n_checks++; if (miso_got.size() != 1 || miso_got[0] !== miso_exp[0]) begin n_fail++; $display("FAIL rstmid_next_miso: got %h want %h", miso_got.size() ? miso_got[0] : 8'h00, miso_exp[0]); end
    n_checks++; if (under_cnt - u0 != exp_under - e0) begin n_fail++; $display("FAIL rstmid_underrun: got %0d want %0d", under_cnt - u0, exp_under - e0); end
  endtask

  task automatic test_random();
    int nb, ph, u0, e0, np;
    for (int f = 0; f < 4; f++) begin
      nb = $urandom_range(1, 3);
      ph = $urandom_range(S + 2, S + 6);
      np = $urandom_range(0, nb - 1);
      u0 = under_cnt; e0 = exp_under;
      mosi_bytes.delete();
      feed_q.delete();
      for (int k = 0; k < nb; k++) mosi_bytes.push_back(8'($urandom));
      for (int k = 0; k < np; k++) feed_q.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) push_tx(8'($urandom));
      rx_got.delete();
      fork
        run_frame(nb * 8, ph);
        feed(ph + 4);
      join
      n_checks++; if (rx_got.size() != nb) begin n_fail++; $display("FAIL rand%0d_rx_count: got %0d want %0d", f, rx_got.size(), nb); end
      for (int k = 0; k < nb && k < rx_got.size(); k++) begin
        n_checks++; if (rx_got[k] !== mosi_bytes[k]) begin n_fail++; $display("FAIL rand%0d_rx[%0d]: got %h want %h", f, k, rx_got[k], mosi_bytes[k]); end
      end
      for (int k = 0; k < nb && k < miso_got.size(); k++) begin
        n_checks++; if (miso_got[k] !== miso_exp[k]) begin n_fail++; $display("FAIL rand%0d_miso[%0d]: got %h want %h", f, k, miso_got[k], miso_exp[k]); end
      end
      n_checks++; if (under_cnt - u0 != exp_under - e0) begin n_fail++; $display("FAIL rand%0d_underrun: got %0d want %0d", f, under_cnt - u0, exp_under - e0); end
    end
    n_checks++; if (over_cnt != 0) begin n_fail++; $display("FAIL overrun_total: got %0d want 0", over_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst(6, "burst", 0);
    test_underrun();
    test_idle_sclk();
    test_abort();
    test_reset_mid();
    test_burst(S + 2, "minphase", 1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on sclk, cs_n and mosi (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL have ports sclk, cs_n, mosi  input  1 each  external SPI pins, asynchronous to clk.
REQ-005 SHALL have port miso  output  1  serial data to the SPI controller.
REQ-006 SHALL have port miso_oe  output  1  high while the frame is selected, for the pad tristate.
REQ-007 SHALL have ports tx_data  input  8 and tx_valid  input  1  for the next byte to transmit.
REQ-008 SHALL have port tx_ready  output  1  high when the tx holding buffer is empty.
REQ-009 SHALL have port rx_data  output  8  for the last complete received byte.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 SHALL have ports overrun and underrun  output  1 each  for one-cycle error pulses.

Function
REQ-012 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, full duplex.
REQ-013 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops, then one extra flop for edge detection; an edge is acted on SYNC_STAGES+1 cycles after the pin changes.
REQ-014 SHALL require each sclk high and low phase to last at least SYNC_STAGES+2 clk periods.
REQ-015 SHALL use states IDLE (cs_n high), SHIFT (cs_n low); IDLE->SHIFT on synced cs_n falling edge; any state->IDLE on synced cs_n high.
REQ-016 SHALL accept a tx byte into the holding buffer when tx_valid and tx_ready are both high; tx_ready SHALL drop the next cycle and rise again the cycle after the buffer moves to the shift register.
REQ-017 SHALL, on the IDLE->SHIFT transition, load tx_shift from the buffer if it is full; otherwise it SHALL load 0x00 and pulse underrun.
REQ-018 SHALL drive miso = tx_shift[7] and miso_oe = 1 in SHIFT, and miso = 0 and miso_oe = 0 in IDLE.
REQ-019 SHALL, on each synced sclk rising edge in SHIFT, shift synced mosi into rx_shift LSB and increment a 3-bit bit counter.
REQ-020 SHALL, on the 8th rising edge (counter 7->0 wrap), present rx_data = the completed byte and pulse rx_valid the following cycle.
REQ-021 SHALL, on synced sclk falling edges, shift tx_shift left by one, except after the 8th rising edge, when it SHALL reload from the buffer per REQ-017 rules (underrun and 0x00 if empty).
REQ-022 SHALL pulse overrun and leave rx_data and rx_valid unchanged if a byte completes within 2 clk cycles of the previous rx_valid (no storage for it); otherwise every completed byte SHALL produce rx_valid.
REQ-023 SHALL, on cs_n deassertion mid-byte, discard the partial rx byte without pulsing rx_valid, clear the bit counter, and keep any unloaded buffer byte for the next frame.
REQ-024 SHALL ignore sclk edges while in IDLE.
REQ-025 SHALL, if a tx handshake and a buffer->shift load occur in the same cycle, perform the load first, so the new byte occupies the now-empty buffer.

Reset
REQ-026 SHALL, while rst is low at a clk edge, force state IDLE, shift registers, bit counter, rx_data = 0x00, buffer empty, tx_ready = 1, and miso, miso_oe, rx_valid, overrun, underrun = 0.
REQ-027 SHALL preset the synchronizers to idle levels (sclk 0, cs_n 1, mosi 0), so that reset release with cs_n already low produces one IDLE->SHIFT transition.
REQ-028 SHALL treat reset during a frame as an abort; the first byte after release starts from a fresh cs_n falling edge.

Verification
REQ-029 SHALL cover: tx 0xA5 preloaded, controller sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data = 0x3C with one rx_valid pulse; no error pulses.
REQ-030 SHALL cover: 3-byte burst (tx 0x01, 0x02, 0x03 fed on tx_ready; mosi 0xF0, 0x0F, 0xFF) -> three rx_valid pulses in order; miso matches; no underrun.
REQ-031 SHALL cover: frame start with the buffer empty -> underrun pulse and miso all-zero for byte 0.
REQ-032 SHALL cover: cs_n raised after 5 bits -> no rx_valid, miso_oe = 0; the next full frame receives 0x81 correctly.
REQ-033 SHALL cover: rst low for 2 cycles mid-byte -> all outputs at REQ-026 values; the next frame works.
REQ-034 SHALL cover: sclk phases of exactly SYNC_STAGES+2 clk periods -> correct data; the checker flags any rx_valid wider than one cycle.
